uart_pixel_assembler: RTL and testbench

//   Upstream neighbour of the grayscale transform stage. Consumes the UART RX byte stream,

---
 rtl/uart_pixel_pkg.sv | 18 +
 rtl/uart_pixel_assembler_timer.sv | 36 +++
 rtl/uart_pixel_assembler.sv | 145 ++++++++++++++
 tb/tb_uart_pixel_assembler.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pixel_pkg.sv
// Shared types for the UART pixel assembler: byte width, capture state encoding and pixel struct.
package uart_pixel_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [1:0] {
    CAP_R = 2'd0,
    CAP_G = 2'd1,
    CAP_B = 2'd2
  } cap_state_e;

  typedef struct packed {
    logic [PIX_W-1:0] red;
    logic [PIX_W-1:0] green;
    logic [PIX_W-1:0] blue;
  } pixel_t;

endpackage

// File: rtl/uart_pixel_assembler_timer.sv
// Saturating idle counter: clears on clr_i, otherwise counts up and holds at TIMEOUT_CYCLES-1,
// where expire_o is asserted.
module pixel_idle_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_pixel_assembler.sv
// Groups UART RX bytes into R,G,B triplets and presents them on a valid/ready pixel port.
// Optional PIXEL_FRAME_EN adds a frame pixel index and the frame_last output.
module uart_pixel_assembler
  import uart_pixel_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FRAME_PIXELS   = 16384
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] rx_data,
  input  logic             rx_valid,
  output logic [PIX_W-1:0] pix_red,
  output logic [PIX_W-1:0] pix_green,
  output logic [PIX_W-1:0] pix_blue,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             overrun,
  input  logic             clr_overrun,
  output logic             timeout_err
`ifdef PIXEL_FRAME_EN
  ,
  output logic             frame_last
`endif
);

  if (TIMEOUT_CYCLES < 2 || FRAME_PIXELS < 1) begin : g_bad_cfg
    $error("uart_pixel_assembler: TIMEOUT_CYCLES must be >= 2 and FRAME_PIXELS >= 1");
  end

  cap_state_e       state_q, state_d;
  logic [PIX_W-1:0] red_q, red_d, green_q, green_d;
  pixel_t           pix_q, pix_d;
  logic             pix_valid_q, pix_valid_d;
  logic             overrun_q, overrun_d;
  logic             timeout_q, timeout_d;
  logic             expire;

  logic handshake, done, slot_full, timed_out;

  assign handshake = pix_valid_q & pix_ready;
  assign done      = rx_valid & (state_q == CAP_B);
  assign slot_full = pix_valid_q & ~pix_ready;
  // A byte in the terminal cycle takes priority over the timeout.
  assign timed_out = expire & ~rx_valid & (state_q != CAP_R);

  pixel_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (rx_valid | (state_q == CAP_R)),
    .expire_o(expire)
  );

  always_comb begin
    state_d     = state_q;
    red_d       = red_q;
    green_d     = green_q;
    pix_d       = pix_q;
    pix_valid_d = pix_valid_q;
    overrun_d   = overrun_q;
    timeout_d   = 1'b0;

    if (rx_valid) begin
      case (state_q)
        CAP_R: begin
          red_d   = rx_data;
          state_d = CAP_G;
        end
        CAP_G: begin
          green_d = rx_data;
          state_d = CAP_B;
        end
        default: state_d = CAP_R;
      endcase
    end else if (timed_out) begin
      state_d   = CAP_R;
      timeout_d = 1'b1;
    end

    if (done && !slot_full) begin
      pix_d       = '{red: red_q, green: green_q, blue: rx_data};
      pix_valid_d = 1'b1;
    end else if (handshake) begin
      pix_valid_d = 1'b0;
    end

    // Set is applied after clear so a simultaneous overrun wins.
    if (clr_overrun) overrun_d = 1'b0;
    if (done && slot_full) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CAP_R;
      red_q       <= '0;
      green_q     <= '0;
      pix_q       <= '0;
      pix_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      red_q       <= red_d;
      green_q     <= green_d;
      pix_q       <= pix_d;
      pix_valid_q <= pix_valid_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
    end
  end

  assign pix_red     = pix_q.red;
  assign pix_green   = pix_q.green;
  assign pix_blue    = pix_q.blue;
  assign pix_valid   = pix_valid_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_q;

`ifdef PIXEL_FRAME_EN
  localparam int IDX_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_PIXELS - 1);

  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (handshake) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign frame_last = pix_valid_q & (idx_q == IDX_LAST);
`endif

endmodule

// File: tb/tb_uart_pixel_assembler.sv
// Self-checking bench for uart_pixel_assembler: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based behavioural model.
module tb_uart_pixel_assembler;

  localparam int T  = 8;
  localparam int FP = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       pix_ready = 1'b0;
  logic       clr_overrun = 1'b0;
  logic [7:0] pix_red, pix_green, pix_blue;
  logic       pix_valid, overrun, timeout_err;
`ifdef PIXEL_FRAME_EN
  logic       frame_last;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_pixel_assembler #(
    .TIMEOUT_CYCLES(T),
    .FRAME_PIXELS  (FP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .pix_red    (pix_red),
    .pix_green  (pix_green),
    .pix_blue   (pix_blue),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .overrun    (overrun),
    .clr_overrun(clr_overrun),
    .timeout_err(timeout_err)
`ifdef PIXEL_FRAME_EN
    ,
    .frame_last (frame_last)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: bytes collected in a queue, idle clocks counted since the last byte.
  logic [7:0]  part[$];
  int          idle = 0;
  bit          m_valid = 0;
  logic [23:0] m_pix = '0;
  bit          m_ovr = 0;
  bit          m_to = 0;
  int          m_idx = 0;
  bit          m_hs, m_done, m_drop;
  logic [23:0] m_new;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      part.delete();
      idle = 0; m_valid = 0; m_pix = '0; m_ovr = 0; m_to = 0; m_idx = 0;
    end else begin
      m_hs = m_valid && pix_ready;
      m_done = 0; m_drop = 0; m_to = 0; m_new = '0;
      if (rx_valid) begin
        part.push_back(rx_data);
        idle = 0;
        if (part.size() == 3) begin
          m_done = 1;
          m_new = {part[0], part[1], part[2]};
          part.delete();
        end
      end else if (part.size() > 0) begin
        idle++;
        if (idle >= T) begin
          part.delete();
          idle = 0;
          m_to = 1;
        end
      end
      if (m_hs) m_idx = (m_idx + 1) % FP;
      if (m_done && (!m_valid || pix_ready)) begin
        m_pix = m_new;
        m_valid = 1;
      end else if (m_done) begin
        m_drop = 1;
      end else if (m_hs) begin
        m_valid = 0;
      end
      if (m_drop) m_ovr = 1;
      else if (clr_overrun) m_ovr = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("pix_valid", 32'(pix_valid), 32'(m_valid));
      if (m_valid) chk("pixel", {8'h0, pix_red, pix_green, pix_blue}, {8'h0, m_pix});
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("timeout_err", 32'(timeout_err), 32'(m_to));
`ifdef PIXEL_FRAME_EN
      chk("frame_last", 32'(frame_last), 32'(m_valid && (m_idx == FP - 1)));
`endif
    end
  end

  task automatic cyc(input bit v, input logic [7:0] d, input bit rdy, input bit clr);
    rx_valid = v; rx_data = d; pix_ready = rdy; clr_overrun = clr;
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0; clr_overrun = 1'b0;
  endtask

  function automatic logic [31:0] pix_now();
    return {8'h0, pix_red, pix_green, pix_blue};
  endfunction

  int first_to, pulses;
  bit to_seen;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_valid", 32'(pix_valid), 32'd0);
    chk("reset_pixel", pix_now(), 32'h0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    chk("reset_timeout", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: basic triplet, one-clock latency
    cyc(1, 8'h10, 1, 0);
    cyc(1, 8'h20, 1, 0);
    cyc(1, 8'h30, 1, 0);
    chk("t1_valid", 32'(pix_valid), 32'd1);
    chk("t1_pixel", pix_now(), 32'h102030);
    cyc(0, 8'h00, 1, 0);
    chk("t1_cleared", 32'(pix_valid), 32'd0);

    // 2: stalled output, second triplet dropped
    cyc(1, 8'd1, 0, 0); cyc(1, 8'd2, 0, 0); cyc(1, 8'd3, 0, 0);
    chk("t2_a_valid", 32'(pix_valid), 32'd1);
    cyc(1, 8'd4, 0, 0); cyc(1, 8'd5, 0, 0);
    chk("t2_no_ovr_yet", 32'(overrun), 32'd0);
    cyc(1, 8'd6, 0, 0);
    chk("t2_overrun", 32'(overrun), 32'd1);
    chk("t2_a_held", pix_now(), 32'h010203);
    cyc(0, 8'h00, 1, 0);
    chk("t2_accepted", 32'(pix_valid), 32'd0);
    chk("t2_ovr_sticky", 32'(overrun), 32'd1);
    cyc(0, 8'h00, 1, 1);
    chk("t2_ovr_cleared", 32'(overrun), 32'd0);

    // 3: timeout after a lone byte
    cyc(1, 8'hAA, 1, 0);
    first_to = 0; pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc(0, 8'h00, 1, 0);
      if (timeout_err) begin
        if (first_to == 0) first_to = i;
        pulses++;
      end
    end
    chk("t3_timeout_cycle", 32'(first_to), 32'd8);
    chk("t3_pulse_count", 32'(pulses), 32'd1);
    cyc(1, 8'd7, 1, 0); cyc(1, 8'd8, 1, 0); cyc(1, 8'd9, 1, 0);
    chk("t3_resync_pixel", pix_now(), 32'h070809);
    chk("t3_resync_valid", 32'(pix_valid), 32'd1);

    // 4: byte lands exactly on the terminal timeout cycle
    to_seen = 0;
    cyc(1, 8'h11, 1, 0);
    for (int i = 0; i < 7; i++) begin
      cyc(0, 8'h00, 1, 0);
      to_seen |= timeout_err;
    end
    cyc(1, 8'h22, 1, 0); to_seen |= timeout_err;
    cyc(1, 8'h33, 1, 0); to_seen |= timeout_err;
    chk("t4_no_timeout", 32'(to_seen), 32'd0);
    chk("t4_pixel", pix_now(), 32'h112233);

    // 5: handshake and blue byte in the same cycle
    cyc(0, 8'h00, 1, 0);
    cyc(1, 8'd1, 0, 0); cyc(1, 8'd2, 0, 0); cyc(1, 8'd3, 0, 0);
    cyc(1, 8'd4, 0, 0); cyc(1, 8'd5, 0, 0);
    cyc(1, 8'd6, 1, 0);
    chk("t5_valid", 32'(pix_valid), 32'd1);
    chk("t5_pixel", pix_now(), 32'h040506);
    chk("t5_no_overrun", 32'(overrun), 32'd0);
    cyc(0, 8'h00, 1, 0);

    // Randomized traffic with occasional idle gaps long enough to time out
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        for (int k = 0; k < T + 2; k++) cyc(0, 8'h00, 1'($urandom_range(0, 1)), 0);
      end else begin
        cyc(($urandom_range(0, 99) < 40), 8'($urandom), ($urandom_range(0, 99) < 60),
            ($urandom_range(0, 99) < 5));
      end
    end

    // 6: asynchronous reset with a pending pixel and a partial triplet
    cyc(0, 8'h00, 1, 0); cyc(0, 8'h00, 1, 0);
    for (int k = 0; k < T + 2; k++) cyc(0, 8'h00, 1, 0);
    cyc(1, 8'd1, 0, 0); cyc(1, 8'd2, 0, 0); cyc(1, 8'd3, 0, 0);
    cyc(1, 8'd4, 0, 0);
    chk("t6_pending", 32'(pix_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(pix_valid), 32'd0);
    chk("t6_async_pixel", pix_now(), 32'h0);
    @(negedge clk);
    cyc(1, 8'h55, 1, 0);
    cyc(1, 8'h66, 1, 0);
    rst_n = 1'b1;
    @(negedge clk);
    cyc(1, 8'hC1, 1, 0); cyc(1, 8'hC2, 1, 0); cyc(1, 8'hC3, 1, 0);
    chk("t6_clean_pixel", pix_now(), 32'hC1C2C3);
    chk("t6_clean_valid", 32'(pix_valid), 32'd1);
    cyc(0, 8'h00, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
